// File: rtl/corr_peak_detector.sv
// Preamble correlation peak detector: threshold arm, windowed max search, hold-off.
// Define CORR_PEAK_CONFIRM_EN to require a repeated peak PERIOD+-TOL samples later.
module corr_peak_detector #(
    parameter int WIDTH   = 22,
    parameter int CNT_W   = 16,
    parameter int WIN     = 16,
    parameter int HOLDOFF = 256,
    parameter int PERIOD  = 64,
    parameter int TOL     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [WIDTH-1:0] CR_in,
    input  logic [WIDTH-1:0] threshold,
    output logic             peak_found,
    output logic [WIDTH-1:0] peak_val,
    output logic [CNT_W-1:0] peak_idx,
    output logic             busy
);

    localparam int WC_W = $clog2(WIN + 1);
    localparam int HC_W = $clog2(HOLDOFF + 1);
    localparam logic [WC_W-1:0] WIN_C  = WC_W'(WIN);
    localparam logic [HC_W-1:0] HOLD_C = HC_W'(HOLDOFF);

    if (WIN < 1 || HOLDOFF < 1 || PERIOD - TOL <= WIN) begin : g_param_err
        $error("corr_peak_detector: illegal WIN/HOLDOFF/PERIOD/TOL");
    end

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        HOLD,
        CONFIRM
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] smp_cnt;
    logic [WIDTH-1:0] max_val, max_val_n;
    logic [CNT_W-1:0] max_idx, max_idx_n;
    logic [WC_W-1:0]  win_cnt, win_n;
    logic [HC_W-1:0]  hold_cnt, hold_n;
    logic             hit;
    logic             close;
    logic             report;

`ifdef CORR_PEAK_CONFIRM_EN
    localparam logic [CNT_W-1:0] OFF_LO = CNT_W'(PERIOD - TOL);
    localparam logic [CNT_W-1:0] OFF_HI = CNT_W'(PERIOD + TOL);
    logic [CNT_W-1:0] off;
    assign off = smp_cnt - max_idx;
`endif

    assign hit  = CR_in > threshold;
    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n   = state;
        max_val_n = max_val;
        max_idx_n = max_idx;
        win_n     = win_cnt;
        hold_n    = hold_cnt;
        close     = 1'b0;
        report    = 1'b0;
        if (ena) begin
            unique case (state)
                IDLE: begin
                    if (hit) begin
                        max_val_n = CR_in;
                        max_idx_n = smp_cnt;
                        win_n     = WC_W'(1);
                        state_n   = SEARCH;
                        close     = (WIN == 1);
                    end
                end
                SEARCH: begin
                    // strict compare keeps the earliest sample on a tie
                    if (CR_in > max_val) begin
                        max_val_n = CR_in;
                        max_idx_n = smp_cnt;
                    end
                    win_n = win_cnt + WC_W'(1);
                    close = (win_n == WIN_C);
                end
                HOLD: begin
                    hold_n = hold_cnt + HC_W'(1);
                    if (hold_n == HOLD_C) state_n = IDLE;
                end
`ifdef CORR_PEAK_CONFIRM_EN
                CONFIRM: begin
                    if (hit && off >= OFF_LO && off <= OFF_HI) begin
                        report  = 1'b1;
                        state_n = HOLD;
                        hold_n  = '0;
                    end else if (off == OFF_HI) begin
                        state_n = IDLE;
                    end
                end
`endif
                default: state_n = IDLE;
            endcase
            if (close) begin
`ifdef CORR_PEAK_CONFIRM_EN
                state_n = CONFIRM;
`else
                report  = 1'b1;
                state_n = HOLD;
                hold_n  = '0;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            smp_cnt    <= '0;
            max_val    <= '0;
            max_idx    <= '0;
            win_cnt    <= '0;
            hold_cnt   <= '0;
            peak_found <= 1'b0;
            peak_val   <= '0;
            peak_idx   <= '0;
        end else begin
            peak_found <= report;
            if (ena) smp_cnt <= smp_cnt + CNT_W'(1);
            max_val  <= max_val_n;
            max_idx  <= max_idx_n;
            win_cnt  <= win_n;
            hold_cnt <= hold_n;
            if (report) begin
                peak_val <= max_val_n;
                peak_idx <= max_idx_n;
            end
        end
    end

endmodule

// File: tb/tb_corr_peak_detector.sv
// Scoreboard bench for corr_peak_detector: array-scan reference model,
// decoupled monitor checking reports, held outputs and busy per sample.
module tb_corr_peak_detector;

    localparam int WIN     = 16;
    localparam int HOLDOFF = 256;
    localparam int PERIOD  = 64;
    localparam int TOL     = 2;
    localparam int TAIL    = WIN + PERIOD + TOL + HOLDOFF + 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ena = 1'b0;
    logic [21:0] CR_in = '0;
    logic [21:0] threshold = '0;
    logic        peak_found;
    logic [21:0] peak_val;
    logic [15:0] peak_idx;
    logic        busy;

    typedef struct {
        int v;
        int idx;
        int pos;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   x[];
    bit   bexp[];
    int   nx = 0;
    int   thr = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_cons;
    int   last_val = 0;
    int   last_idx = 0;

    corr_peak_detector dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .CR_in     (CR_in),
        .threshold (threshold),
        .peak_found(peak_found),
        .peak_val  (peak_val),
        .peak_idx  (peak_idx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, int act, int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d expected=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst)     n_cons <= 0;
        else if (ena) n_cons <= n_cons + 1;
    end

    always @(negedge clk) begin
        if (rst) begin
            if (peak_found) begin
                if (sb.size() == 0) begin
                    chk("spurious_report", 1, 0);
                end else begin
                    e = sb.pop_front();
                    last_val = e.v;
                    last_idx = e.idx;
                    chk("report_pos", n_cons, e.pos + 1);
                end
            end
            chk("peak_val", int'(peak_val), last_val);
            chk("peak_idx", int'(peak_idx), last_idx);
            if (n_cons == 0)
                chk("busy_idle", int'(busy), 0);
            else if (n_cons <= nx)
                chk("busy", int'(busy), int'(bexp[n_cons-1]));
        end
    end

    // Scan the valid-sample array: trigger, window argmax, confirm, hold-off.
    task automatic model();
        int i, t, en, m, r;
        i = 0;
        foreach (bexp[k]) bexp[k] = 1'b0;
        while (i < nx) begin
            if (x[i] <= thr) begin
                i++;
                continue;
            end
            t  = i;
            en = i + WIN - 1;
            if (en >= nx) begin
                for (int j = t; j < nx; j++) bexp[j] = 1'b1;
                break;
            end
            m = t;
            for (int j = t + 1; j <= en; j++) if (x[j] > x[m]) m = j;
            r = en;
`ifdef CORR_PEAK_CONFIRM_EN
            r = -1;
            for (int j = m + PERIOD - TOL; j <= m + PERIOD + TOL && j < nx; j++)
                if (r < 0 && x[j] > thr) r = j;
            if (r < 0) begin
                for (int j = t; j < m + PERIOD + TOL && j < nx; j++) bexp[j] = 1'b1;
                i = m + PERIOD + TOL + 1;
                continue;
            end
`endif
            sb.push_back(exp_t'{x[m], m % 65536, r});
            for (int j = t; j < r + HOLDOFF && j < nx; j++) bexp[j] = 1'b1;
            i = r + HOLDOFF + 1;
        end
    endtask

    task automatic start_seg(int n, int t);
        rst = 1'b0;
        ena = 1'b0;
        sb.delete();
        last_val = 0;
        last_idx = 0;
        nx  = n;
        thr = t;
        x    = new[n];
        bexp = new[n];
        foreach (x[k]) x[k] = 500;
    endtask

    task automatic put_peak(int s);
        x[s]   = 1200;
        x[s+1] = 1500;
        x[s+2] = 3000;
        x[s+3] = 2000;
    endtask

    task automatic drive(int gap);
        int j, c;
        j = 0;
        c = 0;
        while (j < nx) begin
            @(posedge clk);
            #1;
            case (gap)
                0:       ena = 1'b1;
                1:       ena = (c % 5) < 2;
                default: ena = $urandom_range(0, 9) < 7;
            endcase
            c++;
            if (ena) begin
                CR_in = 22'(x[j]);
                j++;
            end else begin
                CR_in = 22'($urandom);
            end
        end
    endtask

    task automatic go(int gap);
        model();
        threshold = 22'(thr);
        @(posedge clk);
        #1 rst = 1'b1;
        drive(gap);
    endtask

    task automatic fin();
        @(posedge clk);
        #1 ena = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("pending_reports", sb.size(), 0);
    endtask

    initial begin
        #12;
        chk("rst_peak_found", int'(peak_found), 0);
        chk("rst_peak_val", int'(peak_val), 0);
        chk("rst_peak_idx", int'(peak_idx), 0);
        chk("rst_busy", int'(busy), 0);

        start_seg(400, 1000); put_peak(10); go(0); fin();

        start_seg(400, 1000);
        x[5] = 1000; x[20] = 4000; x[22] = 3999; x[25] = 4000;
        go(0); fin();

        start_seg(400, 1000); put_peak(10); go(1); fin();

        start_seg(700, 1000);
        put_peak(10); put_peak(125); put_peak(325);
        go(0); fin();

        start_seg(18, 1000); put_peak(10); go(0);
        @(posedge clk);
        #1 ena = 1'b0;
        rst = 1'b0;
        #1;
        chk("midrst_peak_found", int'(peak_found), 0);
        chk("midrst_peak_val", int'(peak_val), 0);
        chk("midrst_peak_idx", int'(peak_idx), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_pending", sb.size(), 0);

        start_seg(400, 1000); put_peak(10); go(0); fin();

        start_seg(500, 1000); x[100] = 3000; x[164] = 2000; go(0); fin();
        start_seg(500, 1000); x[100] = 3000; x[170] = 2000; go(0); fin();

        for (int s = 0; s < 6; s++) begin
            int burst;
            start_seg(1500, int'($urandom_range(500, 3000)));
            burst = 0;
            for (int j = 0; j < nx; j++) begin
                if (j >= nx - TAIL) begin
                    x[j] = 0;
                end else if (burst > 0) begin
                    x[j] = int'($urandom_range(thr - 200, thr + 3000));
                    burst--;
                end else begin
                    x[j] = int'($urandom_range(0, thr));
                    if ($urandom_range(0, 59) == 0) burst = int'($urandom_range(1, 10));
                end
            end
            go(s % 3);
            fin();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
